bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz, used for 1 Hz tick generation.
REQ-002 Parameter SCAN_DIV, default 50_000, clocks per display digit slot.
REQ-003 Parameter DEB_CYCLES, default 500_000, clocks a button level must stay stable before it is accepted.
REQ-004 Port clk, input, 1, system clock; all logic SHALL be rising-edge clk.
REQ-005 Port reset, input, 1, reset; asynchronous, active-high.
REQ-006 Port btnd, input, 1, raw start/pause button, asynchronous and bouncing.
REQ-007 Port btnl, input, 1, raw load button, asynchronous and bouncing.
REQ-008 Port sw, input, 8, preset value: sw[7:4] is the tens BCD digit and sw[3:0] the ones BCD digit.
REQ-009 Port leds, output, 7, segment drive a..g, active-low.
REQ-010 Port ano, output, 4, digit enables, active-low.
REQ-011 Port done, output, 1, high while the count has expired.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and a stability filter of DEB_CYCLES, then a rising-edge detector producing a 1-clk pulse (start_p, load_p).
REQ-013 The block SHALL hold count as two BCD digits, tens and ones, with legal range 00..99.
REQ-014 A free-running divider SHALL emit a 1-clk tick every CLK_HZ clocks; the divider SHALL be cleared on every transition into RUN, so the first decrement occurs CLK_HZ clocks after the start press.
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-016 On load_p in any state, count SHALL take sw, with any digit >9 clamped to 9; the next state SHALL be IDLE and done SHALL be 0.
REQ-017 On start_p in IDLE with count != 00, the FSM SHALL go to RUN; with count == 00 it SHALL stay in IDLE.
REQ-018 On start_p in RUN, the FSM SHALL go to PAUSE; on start_p in PAUSE, it SHALL go to RUN.
REQ-019 On start_p in DONE, the FSM SHALL ignore the press.
REQ-020 On a tick in RUN, count SHALL decrement by 1 in BCD: if ones == 0, ones becomes 9 and tens decrements; otherwise ones decrements.
REQ-021 When a decrement yields 00, the FSM SHALL enter DONE on the same clock edge, and done SHALL be 1 from the next cycle.
REQ-022 In DONE, count SHALL hold at 00 and never wrap to 99; only load_p or reset leaves DONE.
REQ-023 If load_p and start_p occur in the same cycle, load SHALL win and start_p SHALL be discarded.
REQ-024 If load_p and a tick occur in the same cycle, load SHALL win and no decrement SHALL occur.
REQ-025 Ticks in IDLE, PAUSE and DONE SHALL be ignored.
REQ-026 The display SHALL rotate an active slot 0→1→2→3→0 every SCAN_DIV clocks, with exactly one ano bit low per slot.
REQ-027 Slot 0 SHALL show the ones digit and slot 1 the tens digit.
REQ-028 Slots 2 and 3 SHALL be blanked (ano bit high, leds all 1).
REQ-029 In DONE, slots 0 and 1 SHALL blink, blanking during alternate 1 Hz tick periods.
REQ-030 Segment encoding SHALL be the standard decimal pattern, e.g. 0 → 7'b1000000 (gfedcba, active-low).

Reset
REQ-031 reset asserted SHALL force immediately, without waiting for clk: state = IDLE, count = 00, done = 0, all dividers, filters and synchronizers = 0, scan slot = 0, ano = 4'b1110, leds = 7'b1000000.
REQ-032 Reset asserted mid-RUN SHALL abort the countdown; after release the block SHALL wait in IDLE with no pending button pulse.
REQ-033 Reset release SHALL be synchronized to clk by a 2-flop release synchronizer.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2-bit, IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3) and the segment constants for 0–9 and blank.
REQ-035 Exactly one sub-module, btn_conditioner (synchronizer + filter + edge pulse), SHALL be instantiated once per button.
REQ-036 The BCD-to-segment decode SHALL be inline combinational logic.

Verification
REQ-037 With CLK_HZ = 10, SCAN_DIV = 2 and DEB_CYCLES = 3, the bench SHALL cover:
- sw = 8'h12, press btnl, press btnd -> count reads 12,11,10,09 at 10-clk intervals; borrow 10→09 is correct.
- sw = 8'h01, load, start -> after 10 clks count = 00, done = 1 and stays 1 for 100 further clks, count never 99.
- sw = 8'hAF, load -> count = 99 (both digits clamped).
- Run from 05, press btnd after 2 ticks -> PAUSE holds 03 for 50 clks; press again -> resumes with next decrement 10 clks later.
- btnl and btnd pulses forced in the same cycle while in RUN -> state IDLE, count = sw, no decrement.
- Assert reset mid-RUN between clk edges -> outputs take reset values before the next clk edge; bouncing btnd shorter than 3 clks -> no state change.

Source files
------------

// File: rtl/bcd_down_timer_pkg.sv
// Shared FSM encoding, seven-segment constants and BCD helpers for the
// BCD down timer.
package bcd_down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_timer_btn_conditioner.sv
// Raw button conditioning: two-flop synchronizer, stability filter and a
// one-clock pulse on each accepted rising level.
module btn_conditioner #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A new level is accepted only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown with load and start/pause buttons, 1 Hz decrement
// and a four-slot multiplexed seven-segment display (upper two slots blank).
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnd,
  input  logic       btnl,
  input  logic [7:0] sw,
  output logic [6:0] leds,
  output logic [3:0] ano,
  output logic       done
);

  localparam int            DW        = $clog2(CLK_HZ + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_HZ - 1);
  localparam int            SW_W      = $clog2(SCAN_DIV + 1);
  localparam logic [SW_W-1:0] SCAN_LAST = SW_W'(SCAN_DIV - 1);

  logic rst_meta_q, rst_q;
  logic start_p, load_p;

  state_e            state_q, state_d;
  logic [3:0]        tens_q, tens_d, ones_q, ones_d;
  logic [DW-1:0]     div_q, div_d;
  logic              blink_q, blink_d;
  logic              done_q, done_d;
  logic [SW_W-1:0]   scan_q, scan_d;
  logic [1:0]        slot_q, slot_d;
  logic [6:0]        leds_q, leds_d;
  logic [3:0]        ano_q, ano_d;
  logic              tick, cnt_nz, dec_to_zero, blank_digits, show;
  logic [3:0]        digit;
  logic [6:0]        seg;

  // Reset asserts asynchronously everywhere but releases two clocks later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
    .clk(clk), .rst(rst_q), .btn_raw(btnd), .pulse(start_p)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_load (
    .clk(clk), .rst(rst_q), .btn_raw(btnl), .pulse(load_p)
  );

  assign tick        = (div_q == DIV_LAST);
  assign cnt_nz      = (tens_q != 4'd0) || (ones_q != 4'd0);
  assign dec_to_zero = (tens_q == 4'd0) && (ones_q == 4'd1);

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load overrides everything; a tick reaching 00 wins over a pause press.
  always_comb begin
    state_d = state_q;
    if (load_p) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = (start_p && cnt_nz) ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (tick && dec_to_zero) begin
            state_d = ST_DONE;
          end else if (start_p) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: state_d = start_p ? ST_RUN : ST_PAUSE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done_d       = (state_d == ST_DONE);
    blank_digits = (state_q == ST_DONE) && blink_q;
  end

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_p) begin
      tens_d = bcd_clamp(sw[7:4]);
      ones_d = bcd_clamp(sw[3:0]);
    end else if ((state_q == ST_RUN) && tick) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end else begin
      tens_d = tens_q;
      ones_d = ones_q;
    end
  end

  // Divider restarts on entry to RUN so the first decrement is a full second away.
  always_comb begin
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    if (state_d != ST_DONE) begin
      blink_d = 1'b0;
    end else if ((state_q == ST_DONE) && tick) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      scan_d = scan_q + SW_W'(1);
      slot_d = slot_q;
    end
  end

  always_comb begin
    ano_d = 4'b1111;
    digit = 4'd0;
    show  = 1'b0;
    case (slot_q)
      2'd0:    begin ano_d = 4'b1110; digit = ones_q; show = ~blank_digits; end
      2'd1:    begin ano_d = 4'b1101; digit = tens_q; show = ~blank_digits; end
      default: begin ano_d = 4'b1111; digit = 4'd0;   show = 1'b0;          end
    endcase
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    leds_d = show ? seg : SEG_BLANK;
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      div_q   <= '0;
      blink_q <= 1'b0;
      done_q  <= 1'b0;
      scan_q  <= '0;
      slot_q  <= 2'd0;
      leds_q  <= SEG_0;
      ano_q   <= 4'b1110;
    end else begin
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      div_q   <= div_d;
      blink_q <= blink_d;
      done_q  <= done_d;
      scan_q  <= scan_d;
      slot_q  <= slot_d;
      leds_q  <= leds_d;
      ano_q   <= ano_d;
    end
  end

  assign leds = leds_q;
  assign ano  = ano_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Randomized self-checking bench for bcd_down_timer against a count/state
// reference model kept in plain integers.
module tb_bcd_down_timer;

  localparam int CLK_HZ = 10, SCAN_DIV = 2, DEB_CYCLES = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0, reset = 1'b0, btnd = 1'b0, btnl = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [6:0] leds;
  logic [3:0] ano;
  logic       done;

  int checks = 0, fails = 0;
  int model_count = 0;
  int model_state = S_IDLE;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_down_timer #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk(clk), .reset(reset), .btnd(btnd), .btnl(btnl), .sw(sw),
    .leds(leds), .ano(ano), .done(done)
  );

  always #5 clk = ~clk;

  wire [1:0] obs_state = dut.state_q;
  wire [3:0] obs_tens  = dut.tens_q;
  wire [3:0] obs_ones  = dut.ones_q;

  function automatic int obs_count();
    return int'(obs_tens) * 10 + int'(obs_ones);
  endfunction

  function automatic int clamp_val(input logic [7:0] v);
    int t, o;
    t = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
    o = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
    return t * 10 + o;
  endfunction

  task automatic do_load(input logic [7:0] v);
    sw   = v;
    btnl = 1'b1;
    repeat (8) @(negedge clk);
    btnl = 1'b0;
    repeat (8) @(negedge clk);
    model_count = clamp_val(v);
    model_state = S_IDLE;
  endtask

  task automatic wait_state(input int target, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (int'(obs_state) == target) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic press_start(output int cyc);
    btnd = 1'b1;
    wait_state(S_RUN, 20, cyc);
    btnd = 1'b0;
    if (cyc != -1) model_state = S_RUN;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks++; if (leds !== 7'h40) begin fails++; $display("FAIL reset_leds: got %b want 1000000", leds); end
    checks++; if (ano !== 4'b1110) begin fails++; $display("FAIL reset_ano: got %b want 1110", ano); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (int'(obs_state) != S_IDLE || obs_count() != 0) begin
      fails++; $display("FAIL reset_release: state %0d count %0d want 0/0", obs_state, obs_count());
    end
  endtask

  task automatic test_load_clamp;
    logic [7:0] v;
    bit seen0, seen1, bad;
    for (int n = 0; n < 6; n++) begin
      v = (n == 0) ? 8'hAF : 8'($urandom_range(0, 255));
      do_load(v);
      checks++; if (obs_count() != model_count) begin
        fails++; $display("FAIL load_count: sw=%h got %0d want %0d", v, obs_count(), model_count);
      end
      checks++; if (int'(obs_state) != S_IDLE || done !== 1'b0) begin
        fails++; $display("FAIL load_state: state %0d done %b want 0/0", obs_state, done);
      end
      seen0 = 1'b0; seen1 = 1'b0; bad = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (ano == 4'b1110) begin
          seen0 = 1'b1; if (leds !== seg_tab[model_count % 10]) bad = 1'b1;
        end else if (ano == 4'b1101) begin
          seen1 = 1'b1; if (leds !== seg_tab[model_count / 10]) bad = 1'b1;
        end else if (leds !== 7'h7F || $countones(ano) < 3) begin
          bad = 1'b1;
        end
      end
      checks++; if (bad || !seen0 || !seen1) begin
        fails++; $display("FAIL display: count %0d bad=%0d ones_seen=%0d tens_seen=%0d want 0/1/1", model_count, bad, seen0, seen1);
      end
    end
  endtask

  task automatic test_countdown;
    int cyc;
    do_load(8'h12);
    press_start(cyc);
    checks++; if (cyc < 4 || cyc > 8) begin fails++; $display("FAIL cd_start_latency: got %0d want 4..8", cyc); end
    for (int k = 0; k < 3; k++) begin
      repeat (9) @(negedge clk);
      checks++; if (obs_count() != model_count) begin
        fails++; $display("FAIL cd_hold: got %0d want %0d", obs_count(), model_count);
      end
      @(negedge clk);
      model_count--;
      checks++; if (obs_count() != model_count) begin
        fails++; $display("FAIL cd_dec: got %0d want %0d", obs_count(), model_count);
      end
    end
  endtask

  task automatic test_done;
    int cyc;
    bit bad, seen_zero, seen_blank;
    do_load(8'h01);
    press_start(cyc);
    checks++; if (cyc == -1) begin fails++; $display("FAIL done_start: got timeout want RUN"); end
    repeat (10) @(negedge clk);
    checks++; if (obs_count() != 0) begin fails++; $display("FAIL done_count: got %0d want 0", obs_count()); end
    @(negedge clk);
    model_state = S_DONE;
    checks++; if (done !== 1'b1 || int'(obs_state) != S_DONE) begin
      fails++; $display("FAIL done_flag: done %b state %0d want 1/3", done, obs_state);
    end
    bad = 1'b0; seen_zero = 1'b0; seen_blank = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done !== 1'b1 || obs_count() != 0) bad = 1'b1;
      if (ano == 4'b1110) begin
        if (leds === 7'h40) seen_zero = 1'b1;
        else if (leds === 7'h7F) seen_blank = 1'b1;
        else bad = 1'b1;
      end
    end
    checks++; if (bad) begin fails++; $display("FAIL done_hold: got done/count/display deviation want done=1 count=0"); end
    checks++; if (!seen_zero || !seen_blank) begin
      fails++; $display("FAIL done_blink: zero_seen=%0d blank_seen=%0d want 1/1", seen_zero, seen_blank);
    end
    btnd = 1'b1;
    repeat (10) @(negedge clk);
    btnd = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (int'(obs_state) != S_DONE || obs_count() != 0) begin
      fails++; $display("FAIL done_ignore_start: state %0d count %0d want 3/0", obs_state, obs_count());
    end
  endtask

  task automatic test_pause;
    int cyc, hold;
    bit bad;
    do_load(8'h05);
    press_start(cyc);
    for (int k = 0; k < 2; k++) begin
      repeat (10) @(negedge clk);
      model_count--;
    end
    checks++; if (obs_count() != model_count) begin fails++; $display("FAIL pause_pre: got %0d want %0d", obs_count(), model_count); end
    btnd = 1'b1;
    wait_state(S_PAUSE, 20, cyc);
    btnd = 1'b0;
    checks++; if (cyc == -1) begin fails++; $display("FAIL pause_enter: got timeout want PAUSE"); end
    hold = $urandom_range(50, 70);
    bad = 1'b0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (obs_count() != model_count || int'(obs_state) != S_PAUSE) bad = 1'b1;
    end
    checks++; if (bad) begin fails++; $display("FAIL pause_hold: got count %0d state %0d want %0d/2", obs_count(), obs_state, model_count); end
    press_start(cyc);
    checks++; if (cyc == -1) begin fails++; $display("FAIL pause_resume: got timeout want RUN"); end
    repeat (9) @(negedge clk);
    checks++; if (obs_count() != model_count) begin fails++; $display("FAIL resume_hold: got %0d want %0d", obs_count(), model_count); end
    @(negedge clk);
    model_count--;
    checks++; if (obs_count() != model_count) begin fails++; $display("FAIL resume_dec: got %0d want %0d", obs_count(), model_count); end
  endtask

  task automatic test_start_zero;
    do_load(8'h00);
    btnd = 1'b1;
    repeat (10) @(negedge clk);
    btnd = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (int'(obs_state) != S_IDLE || done !== 1'b0) begin
      fails++; $display("FAIL start_zero: state %0d done %b want 0/0", obs_state, done);
    end
  endtask

  task automatic test_load_start_collide;
    int cyc;
    logic [7:0] v;
    bit bad;
    for (int n = 0; n < 3; n++) begin
      do_load({4'($urandom_range(1, 9)), 4'($urandom_range(0, 15))});
      press_start(cyc);
      repeat ($urandom_range(0, 12)) @(negedge clk);
      v = 8'($urandom_range(0, 255));
      sw = v; btnl = 1'b1; btnd = 1'b1;
      repeat (8) @(negedge clk);
      btnl = 1'b0; btnd = 1'b0;
      repeat (8) @(negedge clk);
      model_count = clamp_val(v);
      model_state = S_IDLE;
      checks++; if (int'(obs_state) != S_IDLE || obs_count() != model_count) begin
        fails++; $display("FAIL collide: sw=%h state %0d count %0d want 0/%0d", v, obs_state, obs_count(), model_count);
      end
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (int'(obs_state) != S_IDLE || obs_count() != model_count) bad = 1'b1;
      end
      checks++; if (bad) begin fails++; $display("FAIL collide_hold: got state %0d count %0d want 0/%0d", obs_state, obs_count(), model_count); end
    end
  endtask

  task automatic test_bounce;
    int widths [6] = '{1, 2, 2, 1, 1, 3};
    do_load(8'h37);
    for (int i = 0; i < 6; i++) begin
      btnd = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (widths[i]) @(negedge clk);
    end
    btnd = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (int'(obs_state) != S_IDLE || obs_count() != model_count) begin
      fails++; $display("FAIL bounce: state %0d count %0d want 0/%0d", obs_state, obs_count(), model_count);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    do_load({4'($urandom_range(1, 9)), 4'($urandom_range(0, 9))});
    press_start(cyc);
    repeat ($urandom_range(3, 15)) @(negedge clk);
    btnd = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    model_count = 0;
    model_state = S_IDLE;
    checks++; if (leds !== 7'h40 || ano !== 4'b1110 || done !== 1'b0) begin
      fails++; $display("FAIL midrun_reset_out: leds %b ano %b done %b want 1000000/1110/0", leds, ano, done);
    end
    checks++; if (int'(obs_state) != S_IDLE || obs_count() != 0) begin
      fails++; $display("FAIL midrun_reset_state: state %0d count %0d want 0/0", obs_state, obs_count());
    end
    repeat (2) @(negedge clk);
    btnd = 1'b0;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (int'(obs_state) != S_IDLE || obs_count() != 0 || done !== 1'b0) begin
      fails++; $display("FAIL midrun_release: state %0d count %0d done %b want 0/0/0", obs_state, obs_count(), done);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_clamp();
    test_countdown();
    test_done();
    test_pause();
    test_start_zero();
    test_load_start_collide();
    test_bounce();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
